// File: rtl/sw_cond_pkg.sv
// Shared types and constants for the slide-switch conditioning path.
package sw_cond_pkg;

  typedef enum logic {STABLE = 1'b0, SETTLE = 1'b1} sw_cond_state_t;

  // 10 ms at 50 MHz for the board instance
  localparam int unsigned BOARD_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/sw_conditioner_sync2.sv
// Parameterised two-flop synchronizer with synchronous reset to 0.
module sync2 #(
  parameter int WIDTH = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/sw_conditioner.sv
// Synchronizes and debounces raw switch levels into a stable bus with a one-cycle change pulse.
// state  | meaning
// STABLE | synchronized input matches the committed value
// SETTLE | a candidate value is being qualified by the counter
module sw_conditioner
  import sw_cond_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_sw_raw,
  output logic [WIDTH-1:0] o_sw_stable,
  output logic             o_sw_changed,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  sw_cond_state_t   r_state;
  sw_cond_state_t   w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] w_cand_nxt;
  logic [WIDTH-1:0] r_stable;
  logic             r_changed;
  logic             w_commit;
  logic [WIDTH-1:0] w_sync;
  logic             w_differs;
  logic             w_new_cand;
  logic             w_cnt_done;

  sync2 #(.WIDTH(WIDTH)) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_sw_raw),
    .o_q     (w_sync)
  );

  assign w_differs  = (w_sync != r_stable);
  assign w_new_cand = (w_sync != r_cand);
  assign w_cnt_done = (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= STABLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      STABLE: if (w_differs) w_state_nxt = SETTLE;
      SETTLE: begin
        if (!w_differs)                     w_state_nxt = STABLE;
        else if (!w_new_cand && w_cnt_done) w_state_nxt = STABLE;
      end
      default: w_state_nxt = STABLE;
    endcase
  end

  // A third value restarts qualification so no intermediate code is committed.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_cand_nxt = r_cand;
    w_commit   = 1'b0;
    case (r_state)
      STABLE: begin
        if (w_differs) begin
          w_cand_nxt = w_sync;
          w_cnt_nxt  = CNT_ONE;
        end
      end
      SETTLE: begin
        if (!w_differs) begin
          w_cnt_nxt = '0;
        end else if (w_new_cand) begin
          w_cand_nxt = w_sync;
          w_cnt_nxt  = CNT_ONE;
        end else if (w_cnt_done) begin
          w_commit  = 1'b1;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: w_cnt_nxt = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_cand    <= '0;
      r_stable  <= '0;
      r_changed <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_cand    <= w_cand_nxt;
      r_changed <= w_commit;
      if (w_commit) r_stable <= r_cand;
    end
  end

  assign o_sw_stable  = r_stable;
  assign o_sw_changed = r_changed;
  assign o_busy       = (r_state == SETTLE);

endmodule
